// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-side request/result bundle for the multiply/divide sequencer
//
// Purpose: groups the EX request (start/mdop/operands/flush) and the
// sequencer's responses (stall/busy and the HI/LO write port).
// Ports (signals):
//   start, mdop[1:0], regaData, regbData, flush : EX -> sequencer
//   stall, busy, whi, wlo, wHiData, wLoData     : sequencer -> pipeline / HI-LO file
// Modports: master = EX/pipeline side, slave = sequencer side.
interface muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        mdop;
  logic [DATA_W-1:0] regaData;
  logic [DATA_W-1:0] regbData;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              whi;
  logic              wlo;
  logic [DATA_W-1:0] wHiData;
  logic [DATA_W-1:0] wLoData;

  modport master (
    output start, mdop, regaData, regbData, flush,
    input  stall, busy, whi, wlo, wHiData, wLoData
  );

  modport slave (
    input  start, mdop, regaData, regbData, flush,
    output stall, busy, whi, wlo, wHiData, wLoData
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle mult/multu/div/divu sequencer with HI/LO write port
//
// Purpose: accepts one multiply/divide request from EX, stalls the pipeline
// while iterating one bit per cycle (shift-add multiply, restoring divide),
// then pulses whi/wlo for one cycle with the sign-corrected HI/LO result.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : muldiv_if slave modport (request, stall/busy, HI/LO write port)
module muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    count;
  // |A| for multiply (the addend), |B| for divide (the subtrahend).
  logic [DATA_W-1:0]   opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds the dividend bits still to be shifted in,
  // gradually replaced by quotient bits.
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     rem;
  logic                neg_q, neg_r;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                signed_op, a_neg, b_neg, b_zero, last;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next, prod_fix;
  logic [DATA_W:0]     rem_shift, rem_next;
  logic                div_ge;
  logic [DATA_W-1:0]   q_next, q_fix, r_fix;
  logic                accept;

  // Operand conditioning at accept time.
  always_comb begin
    signed_op = ~bus.mdop[0];
    a_neg     = signed_op & bus.regaData[DATA_W-1];
    b_neg     = signed_op & bus.regbData[DATA_W-1];
    abs_a     = a_neg ? -bus.regaData : bus.regaData;
    abs_b     = b_neg ? -bus.regbData : bus.regbData;
    b_zero    = (bus.regbData == '0);
    accept    = (state == IDLE) && bus.start && !bus.flush;
    last      = (count == CNT_W'(DATA_W-1));
  end

  // One iteration of each algorithm, plus the final sign fix applied to the
  // result of the last iteration so it can be registered straight into HI/LO.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    mul_next  = {mul_sum, acc[DATA_W-1:1]};
    prod_fix  = neg_q ? -mul_next : mul_next;

    rem_shift = {rem[DATA_W-1:0], acc[DATA_W-1]};
    div_ge    = (rem_shift >= {1'b0, opnd});
    rem_next  = div_ge ? (rem_shift - {1'b0, opnd}) : rem_shift;
    q_next    = {acc[DATA_W-2:0], div_ge};
    q_fix     = neg_q ? -q_next : q_next;
    r_fix     = neg_r ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.stall  = 1'b0;
    bus.busy   = (state != IDLE);
    bus.whi    = 1'b0;
    bus.wlo    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.stall = 1'b1;
          if (!bus.mdop[1])  state_next = MUL;
          else if (b_zero)   state_next = DONE;
          else               state_next = DIV;
        end
      end
      MUL, DIV: begin
        bus.stall = 1'b1;
        if (bus.flush)  state_next = IDLE;
        else if (last)  state_next = DONE;
      end
      DONE: begin
        // No stall here: EX advances in the same cycle HI/LO is written.
        bus.whi    = ~bus.flush;
        bus.wlo    = ~bus.flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. A flush during iteration simply freezes these registers; the
  // FSM drops back to IDLE and the next accept reinitialises everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      opnd  <= '0;
      acc   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            rem   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (bus.mdop[1]) begin
              opnd <= abs_b;
              acc  <= {{DATA_W{1'b0}}, abs_a};
              if (b_zero) begin
                // Divide by zero: no trap, architected result is HI=A, LO=~0.
                hi_q <= bus.regaData;
                lo_q <= '1;
              end
            end else begin
              opnd <= abs_a;
              acc  <= {{DATA_W{1'b0}}, abs_b};
            end
          end
        end
        MUL: begin
          if (!bus.flush) begin
            acc   <= mul_next;
            count <= count + 1'b1;
            if (last) {hi_q, lo_q} <= prod_fix;
          end
        end
        DIV: begin
          if (!bus.flush) begin
            acc   <= {acc[2*DATA_W-1:DATA_W], q_next};
            rem   <= rem_next;
            count <= count + 1'b1;
            if (last) begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wHiData = hi_q;
  assign bus.wLoData = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic clk;
  logic rst;

  muldiv_if #(.DATA_W(32)) bus ();

  muldiv_seq #(.DATA_W(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit / signed arithmetic.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    if (!op[1]) begin
      if (op[0]) p = {32'b0, a} * {32'b0, b};
      else       p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (op[0]) begin
      lo = a / b;
      hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      lo = $signed(a) / $signed(b);
      hi = $signed(a) % $signed(b);
    end
  endtask

  // Runs 34 cycles (0..33) starting at cycle 0 with start. Checks the
  // stall/busy/write pattern every cycle against the timing rules and
  // returns the number of pattern errors and the captured write.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_cyc, input int rst_cyc, input int restart_cyc,
                       output int wr_cnt, output int wr_cyc,
                       output logic [31:0] hi, output logic [31:0] lo, output int perr);
    int  last, stall_end, wcyc;
    bit  accepted, dz;
    logic exp_wr, exp_stall, exp_busy;
    accepted = (flush_cyc != 0) && (rst_cyc != 0);
    dz       = op[1] && (b == 32'd0);
    wcyc     = dz ? 1 : 33;
    last     = accepted ? wcyc : 0;
    if (flush_cyc >= 1 && flush_cyc < last) last = flush_cyc;
    if (rst_cyc >= 1 && rst_cyc - 1 < last) last = rst_cyc - 1;
    stall_end = dz ? 0 : ((last < 32) ? last : 32);
    wr_cnt = 0; wr_cyc = -1; hi = '0; lo = '0; perr = 0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      bus.start = (cyc == 0) || (cyc == restart_cyc);
      bus.flush = (cyc == flush_cyc);
      rst       = (cyc != rst_cyc);
      if (cyc == 0) begin
        bus.mdop = op; bus.regaData = a; bus.regbData = b;
      end else begin
        bus.mdop = 2'($urandom); bus.regaData = $urandom; bus.regbData = $urandom;
      end
      #3;
      exp_busy  = (cyc >= 1) && (cyc <= last);
      exp_stall = (cyc == 0 && accepted) || (cyc >= 1 && cyc <= stall_end);
      exp_wr    = (cyc == wcyc) && (last >= wcyc) && (flush_cyc != wcyc);
      if (bus.stall !== exp_stall || bus.busy !== exp_busy ||
          bus.whi !== exp_wr || bus.wlo !== exp_wr) perr++;
      if (cyc == rst_cyc && (bus.wHiData !== 32'd0 || bus.wLoData !== 32'd0)) perr++;
      if (bus.whi === 1'b1) begin
        wr_cnt++; wr_cyc = cyc; hi = bus.wHiData; lo = bus.wLoData;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.flush = 1'b0; rst = 1'b1;
  endtask

  task automatic run_chk(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int restart_cyc);
    int wc, wy, pe;
    logic [31:0] h, l;
    do_op(op, a, b, -1, -1, restart_cyc, wc, wy, h, l, pe);
    chk({name, "_wr_count"}, wc, 1);
    chk({name, "_wr_cycle"}, wy, (op[1] && b == 0) ? 1 : 33);
    chk({name, "_hi"}, h, ehi);
    chk({name, "_lo"}, l, elo);
    chk({name, "_pattern"}, pe, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int wc, wy, pe;
    logic [31:0] h, l, mh, ml, ra, rb;
    logic [1:0] rop;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{2'b01, 32'd0,         32'd12345,     32'd0,         32'd0};

    rst = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.mdop = 2'b00;
    bus.regaData = '0; bus.regbData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_whi", bus.whi, 0);
    chk("rst_wlo", bus.wlo, 0);
    chk("rst_whidata", bus.wHiData, 0);
    chk("rst_wlodata", bus.wLoData, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_chk($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].hi, vecs[i].lo, -1);
    end

    // Flush mid-iteration: back to IDLE in the following cycle, no write.
    do_op(2'b11, 32'd100, 32'd7, 10, -1, -1, wc, wy, h, l, pe);
    chk("flush10_wr_count", wc, 0);
    chk("flush10_pattern", pe, 0);
    // Flush in DONE suppresses the write.
    do_op(2'b11, 32'd100, 32'd7, 33, -1, -1, wc, wy, h, l, pe);
    chk("flush33_wr_count", wc, 0);
    chk("flush33_pattern", pe, 0);
    // Asynchronous reset mid-operation.
    do_op(2'b11, 32'd100, 32'd7, -1, 5, -1, wc, wy, h, l, pe);
    chk("rst5_wr_count", wc, 0);
    chk("rst5_pattern", pe, 0);
    // Flush with start in IDLE: nothing accepted.
    do_op(2'b00, 32'd3, 32'd4, 0, -1, -1, wc, wy, h, l, pe);
    chk("flush_idle_wr_count", wc, 0);
    chk("flush_idle_pattern", pe, 0);
    // Start while busy is ignored; next op accepted right after (cycle 34).
    run_chk("restart", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    run_chk("after_restart", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, -1);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      model(rop, ra, rb, mh, ml);
      run_chk($sformatf("rnd%0d", i), rop, ra, rb, mh, ml, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
